// File: rtl/fifo_rd_stream.sv
// ----------------------------------------------------------------------------
// fifo_rd_stream
//
// Purpose:
//   Pulls words from a first-word-fall-through FIFO and presents them on a
//   valid/ready stream. Words pass through a 2-entry output buffer. That lets
//   the FIFO pop strobe stay independent of out_ready, with no combinational
//   path from out_ready to Rinc, and still sustain one word per cycle.
//
// Configuration:
//   RD_WORDCNT_EN  (macro) when defined, adds the word_count output. It counts
//                  delivered words (handshakes) and wraps modulo 2^CNT_W.
//
// Parameters:
//   DATA_W  width of Rdata / data_out
//   CNT_W   width of word_count (only meaningful with RD_WORDCNT_EN)
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   rd_en       read enable; low pauses FIFO pops, buffered words still drain
//   Rempty      FIFO empty flag; low means Rdata is a valid head word
//   Rdata       FIFO head word
//   Rinc        FIFO pop strobe, one word per edge while high
//   data_out    output word (registered)
//   data_valid  data_out holds a valid word (registered)
//   out_ready   downstream accepts data_out this cycle
//   word_count  delivered-word count (RD_WORDCNT_EN only)
// ----------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              Rempty,
    input  logic [DATA_W-1:0] Rdata,
    output logic              Rinc,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              out_ready
`ifdef RD_WORDCNT_EN
    ,
    output logic [CNT_W-1:0]  word_count
`endif
);

    // Buffer occupancy: number of words held in head/tail.
    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StHalf  = 2'd1;
    localparam logic [1:0] StFull  = 2'd2;

    // A zero-width counter or data path cannot be built.
    if (CNT_W < 1 || DATA_W < 1) begin : g_param_check
        $error("fifo_rd_stream: DATA_W and CNT_W must be at least 1");
    end

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] head_q,  head_d;
    logic [DATA_W-1:0] tail_q,  tail_d;
    logic              valid_q, valid_d;

    logic push;
    logic fire;

    // The pop decision uses only registered occupancy. It never looks at
    // out_ready, so a ready path downstream cannot reach the FIFO.
    assign push = rd_en & ~Rempty & (state_q != StFull) & ~rst;
    assign fire = valid_q & out_ready;

    assign Rinc       = push;
    assign data_out   = head_q;
    assign data_valid = valid_q;

    // ------------------------------------------------------------------------
    // Next-state logic for occupancy and the two buffer entries.
    // head_q is the word being offered. tail_q holds only the second word
    // that was popped while the head was stalled.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;

        case (state_q)
            StEmpty: begin
                if (push) begin
                    head_d  = Rdata;
                    state_d = StHalf;
                end
            end

            StHalf: begin
                case ({push, fire})
                    2'b10: begin
                        tail_d  = Rdata;
                        state_d = StFull;
                    end
                    2'b11: begin
                        // Head leaves and the new word takes its place.
                        head_d = Rdata;
                    end
                    2'b01: begin
                        // head_q keeps the delivered word, so data_out holds
                        // its last value while the buffer is empty.
                        state_d = StEmpty;
                    end
                    default: ;
                endcase
            end

            StFull: begin
                // push is impossible here because Rinc is gated off when full.
                if (fire) begin
                    head_d  = tail_q;
                    state_d = StHalf;
                end
            end

            default: begin
                state_d = StEmpty;
            end
        endcase

        valid_d = (state_d != StEmpty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
        end
    end

`ifdef RD_WORDCNT_EN
    // ------------------------------------------------------------------------
    // Delivered-word counter. It wraps naturally at 2^CNT_W.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (fire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign word_count = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// ----------------------------------------------------------------------------
// tb_fifo_rd_stream
//
// Self-checking bench for fifo_rd_stream. The reference model is a source
// FIFO queue and an output queue of up to two words. Pops, deliveries and
// resets are applied to those queues directly. When RD_WORDCNT_EN is defined,
// CNT_W is 4 and the counter wrap is exercised.
// ----------------------------------------------------------------------------
module tb_fifo_rd_stream;

    localparam int DW = 16;
`ifdef RD_WORDCNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en;
    logic          Rempty;
    logic [DW-1:0] Rdata;
    logic          out_ready;
    wire           Rinc;
    wire           data_valid;
    wire  [DW-1:0] data_out;
    logic          cnt_ok;

    always #5 clk = ~clk;

`ifdef RD_WORDCNT_EN
    wire  [CW-1:0] word_count;
    logic [CW-1:0] exp_cnt;
    assign cnt_ok = (word_count === exp_cnt);
`else
    assign cnt_ok = 1'b1;
`endif

    fifo_rd_stream #(
        .DATA_W(DW),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .Rempty    (Rempty),
        .Rdata     (Rdata),
        .Rinc      (Rinc),
        .data_out  (data_out),
        .data_valid(data_valid),
        .out_ready (out_ready)
`ifdef RD_WORDCNT_EN
        ,
        .word_count(word_count)
`endif
    );

    // Reference model state
    logic [DW-1:0] src_q[$];   // words still in the upstream FIFO
    logic [DW-1:0] buf_q[$];   // words held by the stream buffer
    logic [DW-1:0] last_out;
    logic          exp_rinc;
    logic          exp_valid;
    logic [DW-1:0] exp_dout;

    int errors = 0;
    int checks = 0;

    // Drive one cycle of inputs (called just after a falling edge). Then work
    // out what the DUT should show during this cycle.
    task automatic apply(input logic r, input logic re, input logic rdy, input logic stall);
        rst       = r;
        rd_en     = re;
        out_ready = rdy;
        Rempty    = stall || (src_q.size() == 0);
        Rdata     = Rempty ? DW'($urandom) : src_q[0];
        #1;
        exp_rinc  = re && !Rempty && (buf_q.size() < 2) && !r;
        exp_valid = (buf_q.size() != 0);
        exp_dout  = exp_valid ? buf_q[0] : last_out;
    endtask

    // Advance the model across one rising edge and return at the next falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            buf_q.delete();
            last_out = '0;
`ifdef RD_WORDCNT_EN
            exp_cnt = '0;
`endif
        end else begin
            if (exp_valid && out_ready) begin
                last_out = buf_q.pop_front();
`ifdef RD_WORDCNT_EN
                exp_cnt = exp_cnt + 1'b1;
`endif
            end
            if (exp_rinc) begin
                buf_q.push_back(Rdata);
                void'(src_q.pop_front());
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        src_q.delete();
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) src_q.push_back(DW'(i + 1));
        apply(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (Rinc !== 1'b0) begin
            errors++;
            $display("FAIL reset_rinc_c0: Rinc=%b expected 0", Rinc);
        end
        tick();
        apply(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (Rinc !== 1'b0 || data_valid !== 1'b0 || data_out !== '0 || !cnt_ok) begin
            errors++;
            $display("FAIL reset_c1: Rinc=%b valid=%b data_out=%h cnt_ok=%b expected 0/0/0000/1",
                     Rinc, data_valid, data_out, cnt_ok);
        end
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (data_valid !== 1'b0 || data_out !== '0 || !cnt_ok) begin
            errors++;
            $display("FAIL reset_after: valid=%b data_out=%h cnt_ok=%b expected 0/0000/1",
                     data_valid, data_out, cnt_ok);
        end
        tick();
        src_q.delete();
    endtask

    task automatic test_streaming();
        logic [DW-1:0] got[$];
        int rinc_cnt = 0;
        logic [DW-1:0] want;
        do_reset();
        for (int i = 0; i < 8; i++) src_q.push_back(DW'(i + 1));
        for (int i = 0; i < 11; i++) begin
            apply(1'b0, 1'b1, 1'b1, 1'b0);
            checks++;
            if (Rinc !== exp_rinc || data_valid !== exp_valid || data_out !== exp_dout || !cnt_ok) begin
                errors++;
                $display("FAIL stream c%0d: Rinc=%b/%b valid=%b/%b data_out=%h/%h cnt_ok=%b",
                         i, Rinc, exp_rinc, data_valid, exp_valid, data_out, exp_dout, cnt_ok);
            end
            if (Rinc === 1'b1) rinc_cnt++;
            if (data_valid === 1'b1) got.push_back(data_out);
            tick();
        end
        checks++;
        if (rinc_cnt != 8) begin
            errors++;
            $display("FAIL stream_rinc_count: got %0d expected 8", rinc_cnt);
        end
        checks++;
        if (got.size() != 8) begin
            errors++;
            $display("FAIL stream_word_count: got %0d expected 8", got.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                want = DW'(k + 1);
                checks++;
                if (got[k] !== want) begin
                    errors++;
                    $display("FAIL stream_word%0d: got %h expected %h", k, got[k], want);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] sent[$];
        logic [DW-1:0] got[$];
        logic rdy;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            src_q.push_back(DW'($urandom));
            sent.push_back(src_q[i]);
        end
        for (int i = 0; i < 20; i++) begin
            rdy = !(i >= 3 && i < 7);
            apply(1'b0, 1'b1, rdy, 1'b0);
            checks++;
            if (Rinc !== exp_rinc || data_valid !== exp_valid || data_out !== exp_dout || !cnt_ok) begin
                errors++;
                $display("FAIL backpressure c%0d: Rinc=%b/%b valid=%b/%b data_out=%h/%h cnt_ok=%b",
                         i, Rinc, exp_rinc, data_valid, exp_valid, data_out, exp_dout, cnt_ok);
            end
            // After several stalled cycles the buffer must be full and not popping.
            if (i == 6) begin
                checks++;
                if (Rinc !== 1'b0 || data_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL backpressure_full: Rinc=%b valid=%b expected 0/1", Rinc, data_valid);
                end
            end
            if (data_valid === 1'b1 && rdy) got.push_back(data_out);
            tick();
        end
        checks++;
        if (got.size() != sent.size()) begin
            errors++;
            $display("FAIL backpressure_count: got %0d expected %0d", got.size(), sent.size());
        end else begin
            for (int k = 0; k < sent.size(); k++) begin
                checks++;
                if (got[k] !== sent[k]) begin
                    errors++;
                    $display("FAIL backpressure_word%0d: got %h expected %h", k, got[k], sent[k]);
                end
            end
        end
    endtask

    task automatic test_pause();
        // {rd_en, out_ready, stall}
        logic [2:0] tbl[14] = '{3'b110, 3'b010, 3'b010, 3'b010, 3'b111, 3'b111, 3'b110,
                                3'b100, 3'b100, 3'b010, 3'b010, 3'b010, 3'b011, 3'b110};
        do_reset();
        for (int i = 0; i < 6; i++) src_q.push_back(DW'($urandom));
        for (int i = 0; i < 14; i++) begin
            apply(1'b0, tbl[i][2], tbl[i][1], tbl[i][0]);
            checks++;
            if (Rinc !== exp_rinc || data_valid !== exp_valid || data_out !== exp_dout || !cnt_ok) begin
                errors++;
                $display("FAIL pause c%0d: Rinc=%b/%b valid=%b/%b data_out=%h/%h cnt_ok=%b",
                         i, Rinc, exp_rinc, data_valid, exp_valid, data_out, exp_dout, cnt_ok);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] fresh;
        logic          seen = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) src_q.push_back(DW'($urandom));
        for (int i = 0; i < 10; i++) begin
            // Fill to full with a stalled sink, reset on cycle 3, then stream.
            apply(i == 3, 1'b1, i > 3, 1'b0);
            if (i == 4) fresh = src_q[0];
            checks++;
            if (Rinc !== exp_rinc || data_valid !== exp_valid || data_out !== exp_dout || !cnt_ok) begin
                errors++;
                $display("FAIL reset_mid c%0d: Rinc=%b/%b valid=%b/%b data_out=%h/%h cnt_ok=%b",
                         i, Rinc, exp_rinc, data_valid, exp_valid, data_out, exp_dout, cnt_ok);
            end
            if (i == 3) begin
                checks++;
                if (Rinc !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_mid_rinc: Rinc=%b expected 0", Rinc);
                end
            end
            if (i > 4 && !seen && data_valid === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (data_out !== fresh) begin
                    errors++;
                    $display("FAIL reset_mid_first: data_out=%h expected %h", data_out, fresh);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (src_q.size() < 3 && ($urandom % 2) == 0) src_q.push_back(DW'($urandom));
            apply(($urandom % 50) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
                  ($urandom % 5) == 0);
            checks++;
            if (Rinc !== exp_rinc || data_valid !== exp_valid || data_out !== exp_dout || !cnt_ok) begin
                errors++;
                $display("FAIL random c%0d: Rinc=%b/%b valid=%b/%b data_out=%h/%h cnt_ok=%b",
                         i, Rinc, exp_rinc, data_valid, exp_valid, data_out, exp_dout, cnt_ok);
            end
            tick();
        end
    endtask

`ifdef RD_WORDCNT_EN
    task automatic test_wrap();
        int fires = 0;
        logic [CW-1:0] want;
        do_reset();
        for (int i = 0; i < 20; i++) src_q.push_back(DW'($urandom));
        for (int i = 0; i < 40 && fires < 17; i++) begin
            apply(1'b0, 1'b1, 1'b1, 1'b0);
            if (data_valid === 1'b1) fires++;
            tick();
            if (fires >= 15 && fires <= 17) begin
                want = (fires == 15) ? CW'(15) : CW'(fires - 16);
                checks++;
                if (word_count !== want) begin
                    errors++;
                    $display("FAIL wrap_fire%0d: word_count=%0d expected %0d", fires, word_count, want);
                end
            end
        end
        checks++;
        if (fires != 17) begin
            errors++;
            $display("FAIL wrap_budget: %0d handshakes expected 17", fires);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        rd_en     = 1'b0;
        out_ready = 1'b0;
        Rempty    = 1'b1;
        Rdata     = '0;
        last_out  = '0;
`ifdef RD_WORDCNT_EN
        exp_cnt   = '0;
`endif
        @(negedge clk);
        test_reset();
        test_streaming();
        test_backpressure();
        test_pause();
        test_reset_mid();
        test_random();
`ifdef RD_WORDCNT_EN
        test_wrap();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
